// File: rtl/alu_dec_seq.sv
// alu_dec_seq: converts an unsigned 16-bit value to BCD digits, least
// significant first, by running byte-wise long division by 10 on an
// external ALU. The sequencer only moves registers; every arithmetic step
// goes through the ALU.
// Optional feature: define ALU_DEC_SEQ_EARLY_EXIT_EN to stop as soon as the
// remaining quotient is zero (leading zeros suppressed).
//
// state  | meaning
// IDLE   | waiting for start, ALU idle (OP_0)
// HI_DIV | {r,q[15:8]} / 10 -> qhi
// HI_MOD | {r,q[15:8]} % 10 -> r
// LO_DIV | {r,q[7:0]} / 10  -> q[7:0], q[15:8] <= qhi, shadow old r/q[7:0]
// LO_MOD | {old r,old q[7:0]} % 10 -> r (the new digit)
// EMIT   | digit_valid pulse with digit = r, advance or finish
// FIN    | done pulse, busy drops
module alu_dec_seq #(
  parameter int NDIGITS  = 5,
  parameter int ALU_WAIT = 1,
  parameter int LOG      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        digit_valid,
  output logic [3:0]  digit,
  output logic [2:0]  digit_idx,
  output logic [4:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_o,
  input  logic        _alu_flag_o
);

  // ALU operation encodings used by this sequencer.
  localparam logic [4:0] OP_0         = 5'h00;
  localparam logic [4:0] OP_BA_DIV_10 = 5'h12;
  localparam logic [4:0] OP_BA_MOD_10 = 5'h13;

  localparam int WW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(ALU_WAIT - 1);

  // Logging is done by the surrounding bench; LOG only has to be 0 or 1 here.
  if (NDIGITS < 1 || NDIGITS > 7 || ALU_WAIT < 1 || (LOG != 0 && LOG != 1)) begin : g_bad_param
    $error("alu_dec_seq: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, HI_DIV, HI_MOD, LO_DIV, LO_MOD, EMIT, FIN} state_t;

  state_t         state, state_nx;
  logic [15:0]    q;
  logic [3:0]     r, r_sh;
  logic [7:0]     qhi, qlo_sh;
  logic [WW-1:0]  wait_cnt;
  logic           step_end;
  logic           last_digit;
  logic           exit_now;

  assign step_end   = (wait_cnt == '0);
  assign last_digit = (digit_idx == 3'(NDIGITS - 1));

`ifdef ALU_DEC_SEQ_EARLY_EXIT_EN
  assign exit_now = last_digit || (q == 16'h0000);
`else
  assign exit_now = last_digit;
`endif

  // Next-state and ALU/handshake outputs, all decoded from the current state.
  always_comb begin
    state_nx    = state;
    alu_op      = OP_0;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    digit_valid = 1'b0;
    digit       = 4'h0;
    done        = 1'b0;
    case (state)
      IDLE: if (start) state_nx = HI_DIV;
      HI_DIV: begin
        alu_op = OP_BA_DIV_10;
        alu_a  = q[15:8];
        alu_b  = {4'b0, r};
        if (step_end) state_nx = HI_MOD;
      end
      HI_MOD: begin
        alu_op = OP_BA_MOD_10;
        alu_a  = q[15:8];
        alu_b  = {4'b0, r};
        if (step_end) state_nx = LO_DIV;
      end
      LO_DIV: begin
        alu_op = OP_BA_DIV_10;
        alu_a  = q[7:0];
        alu_b  = {4'b0, r};
        if (step_end) state_nx = LO_MOD;
      end
      LO_MOD: begin
        alu_op = OP_BA_MOD_10;
        alu_a  = qlo_sh;
        alu_b  = {4'b0, r_sh};
        if (step_end) state_nx = EMIT;
      end
      EMIT: begin
        digit_valid = 1'b1;
        digit       = r;
        state_nx    = exit_now ? FIN : HI_DIV;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Working registers: operand capture, ALU result capture on the last wait clock, digit count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= 16'h0000;
      r         <= 4'h0;
      r_sh      <= 4'h0;
      qhi       <= 8'h00;
      qlo_sh    <= 8'h00;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      digit_idx <= 3'd0;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          q         <= value;
          r         <= 4'h0;
          err       <= 1'b0;
          busy      <= 1'b1;
          digit_idx <= 3'd0;
          wait_cnt  <= WAIT_LOAD;
        end
      end else if (state == EMIT) begin
        r <= 4'h0;
        if (!exit_now) digit_idx <= digit_idx + 3'd1;
      end else if (state == FIN) begin
        busy <= 1'b0;
      end else if (!step_end) begin
        wait_cnt <= wait_cnt - 1'b1;
      end else begin
        wait_cnt <= WAIT_LOAD;
        if (!_alu_flag_o) err <= 1'b1;
        if (state == HI_DIV) begin
          qhi <= alu_o;
        end else if (state == HI_MOD) begin
          r <= alu_o[3:0];
        end else if (state == LO_DIV) begin
          q      <= {qhi, alu_o};
          qlo_sh <= q[7:0];
          r_sh   <= r;
        end else begin
          r <= alu_o[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_dec_seq.sv
// Bench for alu_dec_seq: behavioural ALU model, digit scoreboard, two DUTs
// (ALU_WAIT=1 and ALU_WAIT=3).
module tb_alu_dec_seq;

  localparam logic [4:0] OP_0   = 5'h00;
  localparam logic [4:0] OP_DIV = 5'h12;
  localparam logic [4:0] OP_MOD = 5'h13;
  localparam int NDIG = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT 0: defaults
  logic        start = 1'b0;
  logic [15:0] value = 16'h0;
  logic        busy, done, err, digit_valid;
  logic [3:0]  digit;
  logic [2:0]  digit_idx;
  logic [4:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_o;
  logic        flag_n = 1'b1;

  // DUT 1: ALU_WAIT = 3
  logic        start1 = 1'b0;
  logic [15:0] value1 = 16'h0;
  logic        busy1, done1, err1, digit_valid1;
  logic [3:0]  digit1;
  logic [2:0]  digit_idx1;
  logic [4:0]  alu_op1;
  logic [7:0]  alu_a1, alu_b1, alu_o1;
  logic        flag1_n = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_q1[$];

  alu_dec_seq #(.NDIGITS(NDIG), .ALU_WAIT(1), .LOG(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .err(err), .digit_valid(digit_valid),
    .digit(digit), .digit_idx(digit_idx), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_o(alu_o), ._alu_flag_o(flag_n));

  alu_dec_seq #(.NDIGITS(NDIG), .ALU_WAIT(3), .LOG(0)) u_dut_w3 (
    .clk(clk), .reset(reset), .start(start1), .value(value1),
    .busy(busy1), .done(done1), .err(err1), .digit_valid(digit_valid1),
    .digit(digit1), .digit_idx(digit_idx1), .alu_op(alu_op1), .alu_a(alu_a1),
    .alu_b(alu_b1), .alu_o(alu_o1), ._alu_flag_o(flag1_n));

  function automatic logic [7:0] alu_model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    int x;
    x = b * 256 + a;
    if (op == OP_DIV)      return 8'(x / 10);
    else if (op == OP_MOD) return 8'(x % 10);
    else                   return 8'h00;
  endfunction

  assign alu_o  = alu_model(alu_op, alu_a, alu_b);
  assign alu_o1 = alu_model(alu_op1, alu_a1, alu_b1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected digits of v, least significant first, tagged with their index.
  task automatic push_exp(input int v, input bit which, output int n);
    int x;
    x = v;
    n = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (which) exp_q1.push_back({3'(i), 4'(x % 10)});
      else       exp_q.push_back({3'(i), 4'(x % 10)});
      n++;
      x = x / 10;
`ifdef ALU_DEC_SEQ_EARLY_EXIT_EN
      if (x == 0) break;
`endif
    end
  endtask

  // Scoreboard pops
  always @(negedge clk) begin
    if (digit_valid) begin
      if (exp_q.size() == 0) chk("extra_digit", {25'd0, digit_idx, digit}, 32'h7f);
      else chk("digit", {25'd0, digit_idx, digit}, {25'd0, exp_q.pop_front()});
    end
    if (digit_valid1) begin
      if (exp_q1.size() == 0) chk("extra_digit_w3", {25'd0, digit_idx1, digit1}, 32'h7f);
      else chk("digit_w3", {25'd0, digit_idx1, digit1}, {25'd0, exp_q1.pop_front()});
    end
  end

  // Each ALU step of the ALU_WAIT=3 instance must hold op/a/b for exactly 3 clocks
  logic [20:0] prev_t = '0;
  int run_len = 0;
  always @(negedge clk) begin
    if ({alu_op1, alu_a1, alu_b1} == prev_t) run_len++;
    else begin
      if (prev_t[20:16] != OP_0) chk("hold_w3", run_len, 3);
      run_len = 1;
    end
    prev_t = {alu_op1, alu_a1, alu_b1};
  end

  task automatic convert(input logic [15:0] val, input int restart_at, input bit inject, input bit exp_err);
    int n, cycles;
    bit injd;
    injd = 1'b0;
    push_exp(val, 1'b0, n);
    @(negedge clk);
    start = 1'b1;
    value = val;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    start = 1'b0;
    value = 16'($urandom);
    chk("busy_on", busy, 1);
    while (!done && cycles < 400) begin
      start = (cycles == restart_at);
      if (start) value = 16'd999;
      if (inject && !injd && alu_op == OP_MOD) begin
        flag_n = 1'b0;
        injd = 1'b1;
      end
      @(posedge clk);
      cycles++;
      #1 flag_n = 1'b1;
      @(negedge clk);
    end
    chk("latency", cycles, n * 5 + 1);
    chk("err_at_done", err, exp_err);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_off", busy, 0);
    chk("done_1clk", done, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic convert_w3(input logic [15:0] val);
    int n, cycles;
    push_exp(val, 1'b1, n);
    @(negedge clk);
    start1 = 1'b1;
    value1 = val;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    start1 = 1'b0;
    while (!done1 && cycles < 400) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    chk("latency_w3", cycles, n * 13 + 1);
    chk("err_w3", err1, 0);
    chk("sb_empty_w3", exp_q1.size(), 0);
  endtask

  initial begin
    int n, divs, ndone;
    @(negedge clk);
    chk("reset_outs", {busy, done, err, digit_valid, digit, digit_idx, alu_op, alu_a, alu_b}, 0);
    chk("reset_outs_w3", {busy1, done1, err1, digit_valid1, digit1, digit_idx1, alu_op1, alu_a1, alu_b1}, 0);
    @(negedge clk);
    reset = 1'b0;

    convert(16'd12345, 0, 1'b0, 1'b0);
    convert(16'd65535, 0, 1'b0, 1'b0);
    convert(16'd0,     0, 1'b0, 1'b0);
    convert(16'd12345, 3, 1'b0, 1'b0);
    convert(16'd12345, 0, 1'b1, 1'b1);
    chk("err_sticky", err, 1);
    convert(16'd907,   0, 1'b0, 1'b0);

    // Reset in the middle of the third digit's LO_DIV step
    push_exp(12345, 1'b0, n);
    @(negedge clk);
    start = 1'b1;
    value = 16'd12345;
    @(negedge clk);
    start = 1'b0;
    divs = 0;
    for (int i = 0; i < 100 && divs < 2; i++) begin
      @(negedge clk);
      if (digit_idx == 3'd2 && alu_op == OP_DIV) divs++;
    end
    chk("lo_div_reached", divs, 2);
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, OP_0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_remaining", exp_q.size(), 3);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    convert(16'd42, 0, 1'b0, 1'b0);

    convert_w3(16'd100);
    convert_w3(16'd65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
